// File: rtl/core_pkg.sv
// Shared definitions for the corelet write-back path: source select
// encodings and the write-back FSM state type.
package core_pkg;

    localparam logic SRC_OFIFO = 1'b0;
    localparam logic SRC_SFP   = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_FETCH,
        S_RD,
        S_WR,
        S_FIN
    } state_t;

endpackage

// File: rtl/psum_writeback_engine_if.sv
// Bundle of job control, source handshakes and psum SRAM port for the
// write-back engine. master = engine side, slave = surrounding corelet.
interface psum_writeback_engine_if #(
    parameter int COL     = 8,
    parameter int PSUM_BW = 16,
    parameter int DEPTH   = 2048
) ();
    localparam int AW = $clog2(DEPTH);
    localparam int W  = COL * PSUM_BW;

    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   len;
    logic          acc_en;
    logic          relu_en;
    logic          src_sel;

    logic          ofifo_valid;
    logic [W-1:0]  ofifo_data;
    logic          ofifo_rd;
    logic          sfp_valid;
    logic [W-1:0]  sfp_data;
    logic          sfp_ready;

    logic          mem_cen;
    logic          mem_wen;
    logic [AW-1:0] mem_a;
    logic [W-1:0]  mem_d;
    logic [W-1:0]  mem_q;

    logic          busy;
    logic          done;
    logic          err;

    modport master (
        input  start, base_addr, len, acc_en, relu_en, src_sel,
        input  ofifo_valid, ofifo_data, sfp_valid, sfp_data, mem_q,
        output ofifo_rd, sfp_ready, mem_cen, mem_wen, mem_a, mem_d,
        output busy, done, err
    );

    modport slave (
        output start, base_addr, len, acc_en, relu_en, src_sel,
        output ofifo_valid, ofifo_data, sfp_valid, sfp_data, mem_q,
        input  ofifo_rd, sfp_ready, mem_cen, mem_wen, mem_a, mem_d,
        input  busy, done, err
    );
endinterface

// File: rtl/psum_writeback_engine_lane_alu.sv
// One output lane: signed saturating accumulate (or bypass for overwrite)
// followed by optional ReLU.
module psum_lane_alu #(
    parameter int PSUM_BW = 16
) (
    input  logic [PSUM_BW-1:0] stored,
    input  logic [PSUM_BW-1:0] operand,
    input  logic               acc_en,
    input  logic               relu_en,
    output logic [PSUM_BW-1:0] result
);
    localparam logic [PSUM_BW-1:0] MAX_VAL = {1'b0, {(PSUM_BW-1){1'b1}}};
    localparam logic [PSUM_BW-1:0] MIN_VAL = {1'b1, {(PSUM_BW-1){1'b0}}};

    logic [PSUM_BW:0]   sum;
    logic [PSUM_BW-1:0] pre;

    assign sum = {stored[PSUM_BW-1], stored} + {operand[PSUM_BW-1], operand};

    always_comb begin
        pre = operand;
        if (acc_en) begin
            // The two top bits of the widened sum disagree only on overflow.
            if (sum[PSUM_BW] != sum[PSUM_BW-1]) begin
                pre = sum[PSUM_BW] ? MIN_VAL : MAX_VAL;
            end else begin
                pre = sum[PSUM_BW-1:0];
            end
        end
        result = (relu_en && pre[PSUM_BW-1]) ? '0 : pre;
    end
endmodule

// File: rtl/psum_writeback_engine.sv
// Drains OFIFO/SFP vectors into the psum SRAM at consecutive addresses,
// overwriting or accumulating (read-modify-write) with optional ReLU.
module psum_writeback_engine
    import core_pkg::*;
#(
    parameter int COL     = 8,
    parameter int PSUM_BW = 16,
    parameter int DEPTH   = 2048
) (
    input  logic                    clk,
    input  logic                    reset,
    psum_writeback_engine_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int W  = COL * PSUM_BW;
    localparam logic [AW+1:0] DEPTH_W = (AW+2)'(DEPTH);

    state_t        state_reg, state_next;
    logic [AW-1:0] addr_reg;
    logic [AW:0]   cnt_reg;
    logic          acc_reg, relu_reg, src_reg;
    logic [W-1:0]  vec_reg;
    logic          cen_reg, wen_reg, busy_reg, done_reg, err_reg;
    logic [AW+1:0] end_addr;
    logic          range_bad, beat, last;
    logic [W-1:0]  alu_out;

    assign end_addr  = {2'b00, addr_reg} + {1'b0, cnt_reg};
    assign range_bad = end_addr > DEPTH_W;
    assign last      = cnt_reg == (AW+1)'(1);
    assign beat      = (state_reg == S_FETCH) &&
                       ((src_reg == SRC_SFP) ? bus.sfp_valid : bus.ofifo_valid);

    assign bus.ofifo_rd  = beat && (src_reg == SRC_OFIFO);
    assign bus.sfp_ready = beat && (src_reg == SRC_SFP);
    assign bus.mem_cen   = cen_reg;
    assign bus.mem_wen   = wen_reg;
    assign bus.mem_a     = addr_reg;
    assign bus.busy      = busy_reg;
    assign bus.done      = done_reg;
    assign bus.err       = err_reg;
    // Write data is formed in the write cycle itself so accumulate can use mem_q.
    assign bus.mem_d     = (state_reg == S_WR) ? alu_out : '0;

    generate
        for (genvar gi = 0; gi < COL; gi++) begin : g_lane
            psum_lane_alu #(.PSUM_BW(PSUM_BW)) u_lane (
                .stored  (bus.mem_q[gi*PSUM_BW +: PSUM_BW]),
                .operand (vec_reg[gi*PSUM_BW +: PSUM_BW]),
                .acc_en  (acc_reg),
                .relu_en (relu_reg),
                .result  (alu_out[gi*PSUM_BW +: PSUM_BW])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_reg <= S_IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (bus.start) state_next = S_CHECK;
            S_CHECK: state_next = (range_bad || cnt_reg == '0) ? S_FIN : S_FETCH;
            S_FETCH: if (beat) state_next = acc_reg ? S_RD : S_WR;
            S_RD:    state_next = S_WR;
            S_WR:    state_next = last ? S_FIN : S_FETCH;
            S_FIN:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_reg <= '0;
            cnt_reg  <= '0;
            acc_reg  <= 1'b0;
            relu_reg <= 1'b0;
            src_reg  <= SRC_OFIFO;
            vec_reg  <= '0;
            cen_reg  <= 1'b1;
            wen_reg  <= 1'b1;
            busy_reg <= 1'b0;
            done_reg <= 1'b0;
            err_reg  <= 1'b0;
        end else begin
            // Memory strobes and status are registered from the next state.
            cen_reg  <= !(state_next == S_RD || state_next == S_WR);
            wen_reg  <= state_next != S_WR;
            busy_reg <= state_next inside {S_CHECK, S_FETCH, S_RD, S_WR};
            done_reg <= state_next == S_FIN;
            err_reg  <= (state_reg == S_CHECK) && range_bad;
            if (state_reg == S_IDLE && bus.start) begin
                addr_reg <= bus.base_addr;
                cnt_reg  <= bus.len;
                acc_reg  <= bus.acc_en;
                relu_reg <= bus.relu_en;
                src_reg  <= bus.src_sel;
            end
            if (beat) begin
                vec_reg <= (src_reg == SRC_SFP) ? bus.sfp_data : bus.ofifo_data;
            end
            if (state_reg == S_WR) begin
                addr_reg <= addr_reg + 1'b1;
                cnt_reg  <= cnt_reg - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_psum_writeback_engine.sv
// Directed bench for psum_writeback_engine: SRAM model, source drivers,
// a write-sequence model and a per-cycle compare of the memory port.
module tb_psum_writeback_engine;
    localparam int COL     = 8;
    localparam int PSUM_BW = 16;
    localparam int DEPTH   = 2048;
    localparam int AW      = $clog2(DEPTH);
    localparam int W       = COL * PSUM_BW;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    psum_writeback_engine_if #(.COL(COL), .PSUM_BW(PSUM_BW), .DEPTH(DEPTH)) bus ();

    psum_writeback_engine #(.COL(COL), .PSUM_BW(PSUM_BW), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int           addr;
        logic [W-1:0] data;
    } exp_t;

    exp_t          exp_q[$];
    logic [W-1:0]  ref_mem [DEPTH];
    logic [W-1:0]  sram    [DEPTH];
    logic          pre_we;
    logic [AW-1:0] pre_addr;
    logic [W-1:0]  pre_data;
    logic [W-1:0]  o_vecs[$], s_vecs[$], job_vecs[$];
    int            o_head, s_head;
    bit            ofifo_force, sfp_gap, cur_src;
    int            cyc, t0, pops_o, pops_s, done_cnt, job_writes, mem_cmds;
    int            pops_o0, pops_s0, done0;
    int            n_pass, n_total;
    int            wr_rel[$];

    // Single-port synchronous SRAM with a bench-side preload port.
    always @(posedge clk) begin
        if (pre_we) begin
            sram[pre_addr] <= pre_data;
        end else if (!bus.mem_cen) begin
            if (!bus.mem_wen) sram[bus.mem_a] <= bus.mem_d;
            else              bus.mem_q <= sram[bus.mem_a];
        end
    end

    function automatic void check(string name, logic [W-1:0] act, logic [W-1:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h required %h", name, act, req);
    endfunction

    function automatic int lane_of(logic [W-1:0] v, int i);
        logic [PSUM_BW-1:0] x;
        x = v[i*PSUM_BW +: PSUM_BW];
        return int'($signed(x));
    endfunction

    function automatic logic [W-1:0] splat(int val);
        logic [W-1:0] r;
        logic [31:0]  t;
        t = val;
        for (int l = 0; l < COL; l++) r[l*PSUM_BW +: PSUM_BW] = t[PSUM_BW-1:0];
        return r;
    endfunction

    // Lane arithmetic as plain integers: add, clamp to the signed range, ReLU.
    function automatic logic [W-1:0] model_vec(logic [W-1:0] stored, logic [W-1:0] in_v,
                                               bit acc, bit relu);
        logic [W-1:0] r;
        logic [31:0]  t;
        int s, hi, lo;
        hi = (1 << (PSUM_BW-1)) - 1;
        lo = -(1 << (PSUM_BW-1));
        for (int l = 0; l < COL; l++) begin
            s = lane_of(in_v, l);
            if (acc) s += lane_of(stored, l);
            if (s > hi) s = hi;
            if (s < lo) s = lo;
            if (relu && s < 0) s = 0;
            t = s;
            r[l*PSUM_BW +: PSUM_BW] = t[PSUM_BW-1:0];
        end
        return r;
    endfunction

    task automatic monitor();
        exp_t e;
        if (!reset) return;
        if (!bus.mem_cen) mem_cmds++;
        if (!bus.mem_cen && !bus.mem_wen) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL stray_write: addr %0d data %h, required no write", bus.mem_a, bus.mem_d);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", W'(bus.mem_a), W'(e.addr));
                check("wr_data", bus.mem_d, e.data);
                wr_rel.push_back(cyc - t0 + 1);
                job_writes++;
            end
        end else if (!bus.mem_cen) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL stray_read: addr %0d, required no read", bus.mem_a);
            end else begin
                check("rd_addr", W'(bus.mem_a), W'(exp_q[0].addr));
            end
        end
        if (bus.ofifo_rd || bus.sfp_ready)
            check("hs_sel", W'({bus.sfp_ready, bus.ofifo_rd}), W'(cur_src ? 2'b10 : 2'b01));
        if (bus.done) done_cnt++;
    endtask

    task automatic drive();
        bus.ofifo_valid = ofifo_force || (o_head < o_vecs.size());
        bus.ofifo_data  = (o_head < o_vecs.size()) ? o_vecs[o_head]
                                                   : {$urandom, $urandom, $urandom, $urandom};
        bus.sfp_valid   = (s_head < s_vecs.size()) && (!sfp_gap || (cyc % 4 == 0));
        bus.sfp_data    = (s_head < s_vecs.size()) ? s_vecs[s_head] : '0;
    endtask

    task automatic preload(int addr, logic [W-1:0] data);
        @(negedge clk);
        pre_we = 1'b1; pre_addr = AW'(addr); pre_data = data;
        ref_mem[addr] = data;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    task automatic launch(int base, int len, bit acc, bit relu, bit src);
        exp_t e;
        if (base + len <= DEPTH) begin
            for (int i = 0; i < len; i++) begin
                e.addr = base + i;
                e.data = model_vec(ref_mem[base+i], job_vecs[i], acc, relu);
                ref_mem[base+i] = e.data;
                exp_q.push_back(e);
                if (src) s_vecs.push_back(job_vecs[i]);
                else     o_vecs.push_back(job_vecs[i]);
            end
        end
        @(negedge clk);
        bus.start = 1'b1; bus.base_addr = AW'(base); bus.len = (AW+1)'(len);
        bus.acc_en = acc; bus.relu_en = relu; bus.src_sel = src;
        cur_src = src; t0 = cyc + 1; job_writes = 0; wr_rel.delete();
        pops_o0 = pops_o; pops_s0 = pops_s; done0 = done_cnt;
        @(negedge clk);
        // Scramble the job inputs: the engine must hold its latched copy.
        bus.start = 1'b0; bus.base_addr = AW'($urandom); bus.len = (AW+1)'($urandom);
        bus.acc_en = !acc; bus.relu_en = !relu; bus.src_sel = !src;
        check("busy_cycle1", W'(bus.busy), W'(1));
    endtask

    task automatic wait_done(int exp_rel, bit exp_err);
        int rel;
        rel = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk); #1;
            if (bus.done) begin
                rel = cyc - t0 + 1;
                check("err_flag", W'(bus.err), W'(exp_err));
                check("busy_at_done", W'(bus.busy), W'(0));
                break;
            end
        end
        if (exp_rel >= 0 || rel < 0) check("done_cycle", W'(rel), W'(exp_rel < 0 ? rel + 1000 : exp_rel));
        repeat (3) @(negedge clk);
        check("done_once", W'(done_cnt - done0), W'(1));
        check("exp_drained", W'(exp_q.size()), W'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: summary not reached within time limit");
        $fatal(1);
    end

    initial begin
        pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        bus.start = 1'b0; bus.base_addr = '0; bus.len = '0;
        bus.acc_en = 1'b0; bus.relu_en = 1'b0; bus.src_sel = 1'b0;
        bus.ofifo_valid = 1'b0; bus.ofifo_data = '0;
        bus.sfp_valid = 1'b0; bus.sfp_data = '0;
        fork
            forever begin
                @(posedge clk);
                cyc++;
                if (reset && bus.ofifo_rd) begin
                    pops_o++;
                    if (o_head < o_vecs.size()) o_head++;
                end
                if (reset && bus.sfp_ready) begin
                    pops_s++;
                    if (s_head < s_vecs.size()) s_head++;
                end
            end
            forever begin
                @(negedge clk);
                monitor();
                drive();
            end
        join_none

        // Reset values
        #1 reset = 1'b0;
        #1;
        check("rst_ctrl", W'({bus.ofifo_rd, bus.sfp_ready, bus.mem_cen, bus.mem_wen,
                              bus.busy, bus.done, bus.err}), W'(7'b0011000));
        check("rst_mem_a", W'(bus.mem_a), W'(0));
        check("rst_mem_d", bus.mem_d, '0);
        repeat (3) @(negedge clk);
        reset = 1'b1;

        // Overwrite from OFIFO, base 10, three vectors
        job_vecs.delete();
        job_vecs.push_back({16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1});
        job_vecs.push_back(splat(-5));
        job_vecs.push_back(splat(7));
        launch(10, 3, 1'b0, 1'b0, 1'b0);
        wait_done(8, 1'b0);
        check("ow_nwrites", W'(wr_rel.size()), W'(3));
        for (int i = 0; i < wr_rel.size() && i < 3; i++) check("ow_wr_cycle", W'(wr_rel[i]), W'(3 + 2*i));
        check("ow_pops", W'(pops_o - pops_o0), W'(3));
        check("lit_w10_lane3", W'(lane_of(sram[10], 3)), W'(4));
        check("lit_w11", sram[11], {8{16'hFFFB}});
        check("lit_w12", sram[12], {8{16'h0007}});

        // Accumulate into -20 with relu on, then off
        preload(0, splat(-20));
        job_vecs.delete(); job_vecs.push_back(splat(5));
        launch(0, 1, 1'b1, 1'b1, 1'b0);
        wait_done(5, 1'b0);
        check("acc_wr_cycle", W'(wr_rel.size() > 0 ? wr_rel[0] : -1), W'(4));
        check("lit_acc_relu", sram[0], '0);
        preload(0, splat(-20));
        launch(0, 1, 1'b1, 1'b0, 1'b0);
        wait_done(5, 1'b0);
        check("lit_acc_norelu", sram[0], {8{16'hFFF1}});

        // Saturation at both rails, two vectors back to back
        preload(20, {{6{16'h0000}}, 16'h8000, 16'd32760});
        preload(21, splat(1000));
        job_vecs.delete();
        job_vecs.push_back({{6{16'h0003}}, 16'hFFFF, 16'd100});
        job_vecs.push_back(splat(-1000));
        launch(20, 2, 1'b1, 1'b0, 1'b0);
        wait_done(8, 1'b0);
        check("sat_hi", W'(lane_of(sram[20], 0)), W'(32767));
        check("sat_lo", W'(lane_of(sram[20], 1)), W'(-32768));
        check("sat_plain", W'(lane_of(sram[20], 2)), W'(3));
        check("lit_w21", sram[21], '0);

        // Illegal range, empty job, and the last legal word
        ofifo_force = 1'b1;
        mem_cmds = 0;
        job_vecs.delete();
        launch(2040, 9, 1'b0, 1'b0, 1'b0);
        wait_done(2, 1'b1);
        launch(5, 0, 1'b0, 1'b0, 1'b0);
        wait_done(2, 1'b0);
        check("range_no_mem", W'(mem_cmds), W'(0));
        check("range_no_pop", W'(pops_o - pops_o0), W'(0));
        ofifo_force = 1'b0;
        job_vecs.push_back(splat(123));
        launch(2047, 1, 1'b0, 1'b0, 1'b0);
        wait_done(4, 1'b0);

        // SFP source, gapped valid, OFIFO valid held high but unselected
        ofifo_force = 1'b1; sfp_gap = 1'b1;
        job_vecs.delete();
        for (int k = 0; k < 4; k++)
            job_vecs.push_back({16'(k*10+4), 16'(k*10+3), 16'(k*10+2), 16'(k*10+1),
                                16'(k*10), 16'(k*10-1), 16'(k*10-2), 16'(k*10-3)});
        launch(300, 4, 1'b0, 1'b0, 1'b1);
        wait_done(-1, 1'b0);
        check("sfp_pops", W'(pops_s - pops_s0), W'(4));
        check("sfp_no_ofifo", W'(pops_o - pops_o0), W'(0));
        ofifo_force = 1'b0; sfp_gap = 1'b0;

        // Reset mid-job after the second of five writes, then a clean job
        job_vecs.delete();
        for (int k = 0; k < 5; k++) job_vecs.push_back(splat(100 + k));
        launch(100, 5, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            if (job_writes >= 2) break;
        end
        check("abort_after_2", W'(job_writes), W'(2));
        reset = 1'b0;
        #1;
        check("abort_ctrl", W'({bus.ofifo_rd, bus.sfp_ready, bus.mem_cen, bus.mem_wen,
                                bus.busy, bus.done, bus.err}), W'(7'b0011000));
        check("abort_mem_a", W'(bus.mem_a), W'(0));
        check("abort_mem_d", bus.mem_d, '0);
        exp_q.delete();
        o_head = o_vecs.size();
        done0 = done_cnt;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_no_done", W'(done_cnt - done0), W'(0));
        job_vecs.delete();
        job_vecs.push_back(splat(-77));
        job_vecs.push_back(splat(55));
        launch(200, 2, 1'b0, 1'b0, 1'b0);
        wait_done(6, 1'b0);
        check("post_rst_pops", W'(pops_o - pops_o0), W'(2));
        check("lit_w201", sram[201], {8{16'h0037}});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
